// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle instruction control FSM.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive cycles a request waits for ready. "expired" fires in the
// cycle where the count would reach TIMEOUT_CYCLES with ready still low; a
// ready in that same cycle takes priority, so no expiry is raised.
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Clear while no request is pending or when it completes; otherwise count a wait cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (!active || ready)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign expired = active && !ready && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WB with a sticky TRAP on
// illegal opcodes or memory timeouts, plus a retired-instruction counter.
import mc_pkg::*;

module multi_cycle_control #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                ir_write,
    output logic                reg_write,
    output logic                pc_write,
    output logic                branch_eval,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] retired
);
    state_t     state, state_nxt;
    logic [1:0] cause_nxt;
    logic       run;
    logic       timeout;
    logic       wt_ready;

    // Only one of the two requests can be live at once, so one timer serves both.
    assign wt_ready = (state == FETCH) ? imem_ready : dmem_ready;

    wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (imem_req | dmem_req),
        .ready   (wt_ready),
        .expired (timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // run gates the FETCH request so every output stays 0 during reset and
    // imem_req rises on the first clock edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            run <= 1'b0;
        else
            run <= 1'b1;
    end

    // Latch the trap cause on the transition into TRAP; held until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            trap_cause <= CAUSE_NONE;
        else if (state != TRAP && state_nxt == TRAP)
            trap_cause <= cause_nxt;
    end

    // One retired instruction per PC update, wrapping at 2^RETIRE_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retired <= '0;
        else if (pc_write)
            retired <= retired + RETIRE_W'(1);
    end

    // Next-state and trap-cause selection.
    always_comb begin
        state_nxt = state;
        cause_nxt = CAUSE_NONE;
        case (state)
            FETCH: begin
                if (run) begin
                    if (imem_ready) begin
                        state_nxt = DECODE;
                    end else if (timeout) begin
                        state_nxt = TRAP;
                        cause_nxt = CAUSE_IMEM_TO;
                    end
                end
            end
            DECODE: begin
                if (op_legal(opcode)) begin
                    state_nxt = EXECUTE;
                end else begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end
            end
            EXECUTE: begin
                if (opcode == OP_LOAD || opcode == OP_STORE)
                    state_nxt = MEM;
                else if (opcode == OP_BRANCH)
                    state_nxt = FETCH;
                else
                    state_nxt = WB;
            end
            MEM: begin
                if (dmem_ready) begin
                    state_nxt = (opcode == OP_STORE) ? FETCH : WB;
                end else if (timeout) begin
                    state_nxt = TRAP;
                    cause_nxt = CAUSE_DMEM_TO;
                end
            end
            WB:      state_nxt = FETCH;
            default: state_nxt = TRAP;
        endcase
    end

    // Moore-style requests with ready-qualified pulses; TRAP drives everything low but trap.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        branch_eval = 1'b0;
        trap        = (state == TRAP);
        case (state)
            FETCH: begin
                imem_req = run;
                ir_write = run && imem_ready;
            end
            EXECUTE: begin
                if (opcode == OP_BRANCH) begin
                    pc_write    = 1'b1;
                    branch_eval = 1'b1;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                pc_write = dmem_ready && (opcode == OP_STORE);
            end
            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: an instruction-level model expands each
// instruction (opcode + memory wait counts) into its expected per-cycle
// outputs, which are then replayed against the DUT.
module tb_multi_cycle_control;
    localparam int TO = 16;
    localparam int RW = 4;

    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    opcode = '0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_write, reg_write, pc_write, branch_eval, trap;
    logic [1:0]    trap_cause;
    logic [RW-1:0] retired;
    logic [9:0]    obs;

    always #5 clk = ~clk;

    multi_cycle_control #(.TIMEOUT_CYCLES(TO), .RETIRE_W(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .pc_write    (pc_write),
        .branch_eval (branch_eval),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .retired     (retired)
    );

    assign obs = {imem_req, dmem_req, dmem_we, ir_write, reg_write, pc_write, branch_eval, trap, trap_cause};

    typedef struct {
        logic          ir;
        logic          dr;
        logic [6:0]    op;
        logic [9:0]    ex;
        logic [RW-1:0] ret;
        string         tag;
    } rec_t;

    rec_t          q[$];
    logic [RW-1:0] m_ret;
    int            n_checks = 0;
    int            n_err = 0;
    int            dreq_cycles = 0;
    logic [6:0]    legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                     7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic [6:0] pick_illegal();
        logic [6:0] op;
        do op = rop(); while (is_legal(op));
        return op;
    endfunction

    // Expected output vector, same field order as obs.
    function automatic logic [9:0] ev(input bit ireq, input bit dreq, input bit we, input bit irw,
                                      input bit rgw, input bit pcw, input bit be, input bit tr,
                                      input logic [1:0] c);
        return {ireq, dreq, we, irw, rgw, pcw, be, tr, c};
    endfunction

    task automatic push(input logic ir, input logic dr, input logic [6:0] op, input logic [9:0] ex,
                        input string tag);
        rec_t r;
        r.ir = ir; r.dr = dr; r.op = op; r.ex = ex; r.ret = m_ret; r.tag = tag;
        q.push_back(r);
    endtask

    task automatic gen_trap(input logic [1:0] c);
        for (int k = 0; k < 4; k++) push(rb(), rb(), rop(), ev(0,0,0,0,0,0,0,1,c), "trap");
    endtask

    // Expand one instruction; iw/dw are the low-ready cycles before the fetch/memory ready.
    task automatic gen_instr(input logic [6:0] op, input int iw, input int dw, output bit trapped);
        bit st;
        trapped = 1'b0;
        for (int k = 0; k < iw && k < TO; k++) push(1'b0, rb(), rop(), ev(1,0,0,0,0,0,0,0,0), "fetch_wait");
        if (iw >= TO) begin gen_trap(2'b10); trapped = 1'b1; return; end
        push(1'b1, rb(), rop(), ev(1,0,0,1,0,0,0,0,0), "fetch_acc");
        push(rb(), rb(), op, ev(0,0,0,0,0,0,0,0,0), "decode");
        if (!is_legal(op)) begin gen_trap(2'b01); trapped = 1'b1; return; end
        if (op == BRANCH) begin
            push(rb(), rb(), op, ev(0,0,0,0,0,1,1,0,0), "exec_branch");
            m_ret++;
            return;
        end
        push(rb(), rb(), op, ev(0,0,0,0,0,0,0,0,0), "execute");
        if (op == LOAD || op == STORE) begin
            st = (op == STORE);
            for (int k = 0; k < dw && k < TO; k++) push(rb(), 1'b0, op, ev(0,1,st,0,0,0,0,0,0), "mem_wait");
            if (dw >= TO) begin gen_trap(2'b11); trapped = 1'b1; return; end
            push(rb(), 1'b1, op, ev(0,1,st,0,0,st,0,0,0), "mem_acc");
            if (st) begin m_ret++; return; end
        end
        push(rb(), rb(), op, ev(0,0,0,0,1,1,0,0,0), "wb");
        m_ret++;
    endtask

    // Replay n records (all if n<0): drive after the edge, check at the falling edge.
    task automatic run_queue(input int n);
        rec_t r;
        int   i = 0;
        while (q.size() > 0 && (n < 0 || i < n)) begin
            r = q.pop_front();
            i++;
            imem_ready = r.ir; dmem_ready = r.dr; opcode = r.op;
            @(negedge clk);
            chk(r.tag, 64'(obs), 64'(r.ex));
            chk({r.tag, "_retired"}, 64'(retired), 64'(r.ret));
            if (dmem_req) dreq_cycles++;
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
    endtask

    // Async reset with readies high, hold, release mid-cycle; returns 1ns after the first edge.
    task automatic do_reset();
        #1;
        reset = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = rop();
        #1;
        chk("rst_async_out", 64'(obs), 64'd0);
        chk("rst_async_retired", 64'(retired), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_out", 64'(obs), 64'd0);
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_ret = '0;
    endtask

    initial begin
        bit t;
        logic [6:0] op;
        int iw, dw;

        // R-type with immediate ready: 4 cycles, retired=1
        do_reset();
        chk("first_edge_imem_req", 64'(imem_req), 64'd1);
        gen_instr(RTYPE, 0, 0, t);
        run_queue(-1);
        chk("rtype_retired", 64'(retired), 64'd1);

        // Load with 3 dmem wait cycles: dmem_req for 4 cycles
        do_reset();
        dreq_cycles = 0;
        gen_instr(LOAD, 0, 3, t);
        run_queue(-1);
        chk("load_dreq_cycles", 64'(dreq_cycles), 64'd4);

        // Illegal opcode traps with cause 01
        do_reset();
        gen_instr(7'b1111111, 0, 0, t);
        run_queue(-1);

        // Fetch timeout vs. ready on the last allowed cycle
        do_reset();
        gen_instr(RTYPE, TO, 0, t);
        run_queue(-1);
        do_reset();
        gen_instr(RTYPE, TO - 1, 0, t);
        run_queue(-1);
        chk("fetch_edge_retired", 64'(retired), 64'd1);

        // Memory timeout vs. ready on the last allowed cycle
        do_reset();
        gen_instr(LOAD, 0, TO, t);
        run_queue(-1);
        do_reset();
        gen_instr(STORE, 0, TO - 1, t);
        run_queue(-1);

        // Reset during a store's memory wait
        do_reset();
        gen_instr(RTYPE, 0, 0, t);
        gen_instr(STORE, 0, 10, t);
        run_queue(4 + 3 + 2);
        chk("pre_reset_dmem_req", 64'(dmem_req), 64'd1);
        chk("pre_reset_retired", 64'(retired), 64'd1);
        reset = 1'b0;
        #1;
        chk("reset_drops_dmem_req", 64'(dmem_req), 64'd0);
        chk("reset_clears_retired", 64'(retired), 64'd0);
        q.delete();
        do_reset();
        chk("post_reset_imem_req", 64'(imem_req), 64'd1);
        gen_instr(STORE, 1, 0, t);
        run_queue(-1);

        // 17 branches with a 4-bit counter wrap to 1
        do_reset();
        for (int k = 0; k < 17; k++) gen_instr(BRANCH, 0, 0, t);
        run_queue(-1);
        chk("wrap_retired", 64'(retired), 64'd1);

        // Random instruction streams
        for (int p = 0; p < 30; p++) begin
            do_reset();
            for (int k = 0; k < 10; k++) begin
                op = ($urandom_range(0, 11) == 0) ? pick_illegal() : legal_ops[$urandom_range(0, 8)];
                iw = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 3, TO + 1) : $urandom_range(0, 3);
                dw = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 3, TO + 1) : $urandom_range(0, 3);
                gen_instr(op, iw, dw, t);
                if (t) break;
            end
            run_queue(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles a memory request may wait for ready before trapping.
REQ-002 The module SHALL have parameter RETIRE_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 The module SHALL have these ports, one per line as name direction width meaning:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- opcode  input  7  instruction[6:0] from the instruction register
- imem_ready  input  1  instruction memory data valid this cycle
- dmem_ready  input  1  data memory access complete this cycle
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write strobe, qualified by dmem_req
- ir_write  output  1  load instruction register, one-cycle pulse
- reg_write  output  1  register file write, one-cycle pulse
- pc_write  output  1  PC update, one-cycle pulse
- branch_eval  output  1  PC update conditional on datapath branch result
- trap  output  1  sticky trap flag
- trap_cause  output  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout
- retired  output  RETIRE_W  count of completed instructions

Function
REQ-004 The FSM SHALL have the states FETCH, DECODE, EXECUTE, MEM, WB and TRAP.
REQ-005 In FETCH, the FSM SHALL hold imem_req high until it samples imem_ready=1, then pulse ir_write for that cycle and move to DECODE.
REQ-006 DECODE SHALL last one cycle and go to TRAP with cause 01 for any opcode other than 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 or 0010111; otherwise it SHALL go to EXECUTE.
REQ-007 EXECUTE SHALL last one cycle:
- load/store go to MEM
- branch pulses pc_write and branch_eval, then goes to FETCH
- all other opcodes go to WB
REQ-008 In MEM, the FSM SHALL hold dmem_req high, with dmem_we=1 for stores, until dmem_ready=1.
- Store: pulse pc_write, go to FETCH.
- Load: go to WB.
REQ-009 WB SHALL last one cycle, pulse reg_write and pc_write together, then go to FETCH.
REQ-010 With zero wait states the latency from entering FETCH to re-entering FETCH SHALL be:
- branch 3 cycles
- store, R/I-type, LUI, AUIPC, JAL, JALR 4 cycles
- load 5 cycles
REQ-011 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the matching ready is low.
- When it reaches TIMEOUT_CYCLES with ready still low, the FSM SHALL go to TRAP with cause 10 (FETCH) or 11 (MEM).
- A ready arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL win; no trap is raised.
REQ-012 TRAP SHALL be absorbing until reset.
- trap=1 and trap_cause are held.
- imem_req, dmem_req and all write pulses are 0.
REQ-013 retired SHALL increment by one on every pc_write pulse and wrap modulo 2^RETIRE_W.
REQ-014 A ready input that arrives while its request is low SHALL be ignored.
REQ-015 The write pulses SHALL be mutually exclusive except as follows:
- reg_write and pc_write together in WB
- pc_write and branch_eval together in EXECUTE

Reset
REQ-016 While reset=0, the state SHALL be FETCH and all outputs 0: trap=0, trap_cause=00, retired=0, wait counter 0.
REQ-017 An asserted reset mid-request SHALL drop imem_req and dmem_req asynchronously and discard the transaction.
REQ-018 After reset deasserts, imem_req SHALL assert on the first clock edge.

Structure
REQ-019 Package mc_pkg SHALL hold:
- the state enum
- the nine opcode localparams
- the trap_cause encodings
REQ-020 The wait counter with its timeout compare SHALL be the sub-module wait_timer, parametrised by TIMEOUT_CYCLES; all other logic is in multi_cycle_control.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- R-type 0110011, imem_ready high continuously -> ir_write in cycle 1, reg_write+pc_write in cycle 4, retired=1.
- Load 0000011, dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, reg_write 1 cycle later, 8 cycles total.
- Opcode 1111111 -> trap=1, trap_cause=01 on the cycle after DECODE; no further imem_req.
- imem_ready held low, TIMEOUT_CYCLES=16 -> trap_cause=10 after 16 wait cycles; ready on the 16th cycle -> no trap.
- reset pulled low during a store MEM wait -> dmem_req falls immediately; after release FETCH, retired=0.
- RETIRE_W=4, 17 branches -> retired=1 after the wrap.
